// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers the program byte stream in a small FIFO and
// keeps the instruction register and step counter that the decoder follows.
module instr_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       rIR_enable,
    input  logic       counter_clear,
    input  logic       done,
    input  logic       data_in_select,
    output logic [7:0] rIR_data,
    output logic [1:0] counter,
    output logic [7:0] data_in,
    output logic       stall,
    output logic       illegal,
    output logic [7:0] instr_count
);

    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic [7:0] ir_q, ir_d;
    logic [1:0] counter_q, counter_d;
    logic       illegal_q, illegal_d;
    logic [7:0] instr_count_q, instr_count_d;

    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic       fetch;
    logic       imm;
    logic       recover;
    logic [7:0] head;

    assign fifo_empty  = (count_q == 3'd0);
    assign fifo_full   = (count_q == 3'd4);
    assign in_ready    = !fifo_full;
    assign push        = in_valid & in_ready;
    assign head        = mem_q[rd_ptr_q];
    assign data_in     = fifo_empty ? 8'h00 : head;
    assign stall       = data_in_select & fifo_empty;
    assign fetch       = rIR_enable & counter_clear & !stall;
    assign imm         = data_in_select & !fifo_empty;
    // Fetch wins over an immediate request so a byte is never popped twice.
    assign pop         = fetch ? !fifo_empty : imm;
    assign recover     = !stall && !counter_clear && (counter_q == 2'd3);

    assign rIR_data    = ir_q;
    assign counter     = counter_q;
    assign illegal     = illegal_q;
    assign instr_count = instr_count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ir_d          = ir_q;
        counter_d     = counter_q;
        illegal_d     = 1'b0;
        instr_count_d = instr_count_q;
        if (fetch) begin
            ir_d = fifo_empty ? 8'h00 : head;
        end else if (recover) begin
            ir_d = 8'h00;
        end
        if (stall) begin
            counter_d = counter_q;
        end else if (counter_clear) begin
            counter_d = 2'd0;
        end else if (counter_q == 2'd3) begin
            counter_d = 2'd0;
            illegal_d = 1'b1;
        end else begin
            counter_d = counter_q + 2'd1;
        end
        if (done && !stall && (instr_count_q != 8'hFF)) begin
            instr_count_d = instr_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
            wr_ptr_q      <= 2'd0;
            rd_ptr_q      <= 2'd0;
            count_q       <= 3'd0;
            ir_q          <= 8'h00;
            counter_q     <= 2'd0;
            illegal_q     <= 1'b0;
            instr_count_q <= 8'h00;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ir_q          <= ir_d;
            counter_q     <= counter_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: the bench plays the decoder by hand and
// compares every output against hand-computed values.
module tb_instr_sequencer;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       rIR_enable;
    logic       counter_clear;
    logic       done;
    logic       data_in_select;
    logic [7:0] rIR_data;
    logic [1:0] counter;
    logic [7:0] data_in;
    logic       stall;
    logic       illegal;
    logic [7:0] instr_count;

    int errors = 0;
    int checks = 0;

    instr_sequencer dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .rIR_enable(rIR_enable),
        .counter_clear(counter_clear),
        .done(done),
        .data_in_select(data_in_select),
        .rIR_data(rIR_data),
        .counter(counter),
        .data_in(data_in),
        .stall(stall),
        .illegal(illegal),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's worth of stream and decoder strobes.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ire,
                                 input logic cc, input logic dn, input logic dis);
        in_valid       = v;
        in_data        = d;
        rIR_enable     = ire;
        counter_clear  = cc;
        done           = dn;
        data_in_select = dis;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".ir"},       rIR_data, 8'h00);
        checkOutput({tag, ".counter"},  {6'd0, counter}, 8'h00);
        checkOutput({tag, ".in_ready"}, {7'd0, in_ready}, 8'h01);
        checkOutput({tag, ".stall"},    {7'd0, stall}, 8'h00);
        checkOutput({tag, ".data_in"},  data_in, 8'h00);
        checkOutput({tag, ".icount"},   instr_count, 8'h00);
        checkOutput({tag, ".illegal"},  {7'd0, illegal}, 8'h00);
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkReset("reset");
        step();
        reset_n = 1'b1;

        // MOV B,C: single-byte instruction retiring at step 0
        applyStimulus(1'b1, 8'h41, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("mov.ir_idle", rIR_data, 8'h00);
        checkOutput("mov.head", data_in, 8'h41);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("mov.ir", rIR_data, 8'h41);
        checkOutput("mov.counter", {6'd0, counter}, 8'h00);
        checkOutput("mov.empty", data_in, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("mov.icount", instr_count, 8'h01);
        checkOutput("mov.ir_back", rIR_data, 8'h00);

        // MVI A with immediate already buffered; push and pop overlap at occupancy 1
        applyStimulus(1'b1, 8'h3E, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("mvi.ir", rIR_data, 8'h3E);
        checkOutput("mvi.imm", data_in, 8'h5A);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("mvi.stall", {7'd0, stall}, 8'h00);
        step();
        checkOutput("mvi.counter1", {6'd0, counter}, 8'h01);
        checkOutput("mvi.popped", data_in, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("mvi.icount", instr_count, 8'h02);
        checkOutput("mvi.ir_back", rIR_data, 8'h00);

        // MVI with late immediate: stall holds the counter until the byte arrives
        applyStimulus(1'b1, 8'h3E, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("late.ir", rIR_data, 8'h3E);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("late.stall", {7'd0, stall}, 8'h01);
            step();
            checkOutput("late.hold", {6'd0, counter}, 8'h00);
        end
        checkOutput("late.icount_frozen", instr_count, 8'h02);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("late.counter_still", {6'd0, counter}, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("late.unstall", {7'd0, stall}, 8'h00);
        checkOutput("late.imm", data_in, 8'h5A);
        step();
        checkOutput("late.counter1", {6'd0, counter}, 8'h01);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("late.icount", instr_count, 8'h03);

        // ADD B: three steps, retires on step 2
        applyStimulus(1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("add.ir", rIR_data, 8'h80);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("add.step1", {6'd0, counter}, 8'h01);
        step();
        checkOutput("add.step2", {6'd0, counter}, 8'h02);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("add.step0", {6'd0, counter}, 8'h00);
        checkOutput("add.icount", instr_count, 8'h04);

        // Illegal 0xFF: counter runs off the end and the sequencer recovers
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("ill.ir", rIR_data, 8'hFF);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step();
            checkOutput("ill.count_up", {6'd0, counter}, 8'(i));
            checkOutput("ill.no_pulse", {7'd0, illegal}, 8'h00);
        end
        step();
        checkOutput("ill.counter0", {6'd0, counter}, 8'h00);
        checkOutput("ill.ir0", rIR_data, 8'h00);
        checkOutput("ill.pulse", {7'd0, illegal}, 8'h01);
        checkOutput("ill.icount", instr_count, 8'h04);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("ill.pulse_end", {7'd0, illegal}, 8'h00);

        // Backpressure: fill the FIFO while the decoder holds the counter
        applyStimulus(1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("bp.ir", rIR_data, 8'h80);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(i * 8'h11), 1'b0, 1'b1, 1'b0, 1'b0);
            #1;
            checkOutput("bp.ready", {7'd0, in_ready}, 8'h01);
            step();
        end
        checkOutput("bp.full", {7'd0, in_ready}, 8'h00);
        checkOutput("bp.head", data_in, 8'h11);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("bp.still_full", {7'd0, in_ready}, 8'h00);
        checkOutput("bp.head_kept", data_in, 8'h11);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("bp.fetch_full", rIR_data, 8'h11);
        checkOutput("bp.after_pop", data_in, 8'h22);
        checkOutput("bp.ready_again", {7'd0, in_ready}, 8'h01);
        step();
        checkOutput("bp.push_pop_ir", rIR_data, 8'h22);
        checkOutput("bp.push_pop_head", data_in, 8'h33);
        checkOutput("bp.push_pop_ready", {7'd0, in_ready}, 8'h01);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("bp.busy", {6'd0, counter}, 8'h01);

        // Asynchronous reset mid-instruction, away from any clock edge
        #2;
        reset_n = 1'b0;
        #1;
        checkReset("midreset");
        step();
        #2;
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("post.ir", rIR_data, 8'h00);
        checkOutput("post.counter", {6'd0, counter}, 8'h00);
        checkOutput("post.fifo", data_in, 8'h00);

        // Retired count saturates at 0xFF
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 254; i++) step();
        checkOutput("sat.below", instr_count, 8'hFE);
        step();
        checkOutput("sat.reach", instr_count, 8'hFF);
        for (int i = 0; i < 5; i++) step();
        checkOutput("sat.hold", instr_count, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
